// File: rtl/priority_encoder_q_if.sv
// Request/code bundle for priority_encoder_q: capture side (en, req),
// code handshake (code, valid, ready) and status (pending, overflow).
// Ports: master = encoder side, slave = producer/consumer side.
interface priority_encoder_q_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         en;        // request capture enable
  logic [N-1:0] req;       // multi-hot request strobes
  logic [W-1:0] code;      // index of selected pending bit, 0 when idle
  logic         valid;     // at least one bit pending
  logic         ready;     // consumer accepts code this cycle
  logic [N-1:0] pending;   // current pending register
  logic         overflow;  // one-cycle pulse on a merged (colliding) request

  modport master (
    input  en, req, ready,
    output code, valid, pending, overflow
  );

  modport slave (
    output en, req, ready,
    input  code, valid, pending, overflow
  );
endinterface

// File: rtl/priority_encoder_q.sv
// Purpose: sequential N-to-log2(N) priority encoder; captures multi-hot
//   requests into a pending register and serializes them as binary codes.
// Latency: a req bit captured at edge t is visible after edge t; one code
//   per cycle under continuous ready, the accepted bit is gone after the accept edge.
// Backpressure: with valid=1 and ready=0 the pending set only grows; a newly
//   set higher-priority bit may preempt code, consumer samples code on accept only.
// Ports: clk, reset (sync, active-high); bus (master modport) carries
//   en/req in, code/valid/ready handshake, pending and overflow status out.
module priority_encoder_q #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  priority_encoder_q_if.master   bus
);
  localparam int W = $clog2(N);

  logic [N-1:0] pending_q;
  logic         overflow_q;

  logic [W-1:0] sel;
  logic         acc;
  logic [N-1:0] clr_mask;
  logic [N-1:0] set_mask;

  // Priority select. The loop runs from lowest to highest priority so the
  // last matching bit (the winner) overwrites earlier ones.
  always_comb begin
    sel = '0;
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pending_q[i]) sel = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pending_q[i]) sel = W'(i);
      end
    end
  end

  assign acc      = (|pending_q) & bus.ready;
  assign clr_mask = acc ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
  assign set_mask = bus.en ? bus.req : '0;

  // Set after clear: a bit re-requested in its own accept cycle stays
  // pending as a fresh event and is not an overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= (pending_q & ~clr_mask) | set_mask;
      overflow_q <= |(set_mask & pending_q & ~clr_mask);
    end
  end

  // sel is already 0 when nothing is pending, so code needs no extra gating.
  assign bus.code     = sel;
  assign bus.valid    = |pending_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_priority_encoder_q.sv
// Directed bench for priority_encoder_q: one MSB-first and one LSB-first
// instance driven by the same stimulus, observed as {valid,code,pending,overflow}.
module tb_priority_encoder_q;
  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] req;
  logic       ready;

  int checks = 0;
  int errors = 0;

  priority_encoder_q_if #(.N(8)) bus0 ();
  priority_encoder_q_if #(.N(8)) bus1 ();

  assign bus0.en = en;  assign bus0.req = req;  assign bus0.ready = ready;
  assign bus1.en = en;  assign bus1.req = req;  assign bus1.ready = ready;

  priority_encoder_q #(.N(8), .LSB_FIRST(1'b0)) dut_msb (.clk(clk), .reset(reset), .bus(bus0));
  priority_encoder_q #(.N(8), .LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  // Observed state: {valid, code[2:0], pending[7:0], overflow}
  logic [12:0] st0, st1;
  assign st0 = {bus0.valid, bus0.code, bus0.pending, bus0.overflow};
  assign st1 = {bus1.valid, bus1.code, bus1.pending, bus1.overflow};

  logic [12:0] exp0, exp1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; req = 8'hFF; ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp0 = 13'h0; exp1 = 13'h0;
      checks++;
      if (st0 !== exp0) begin errors++; $display("FAIL reset_hold msb cyc%0d: got %h expected %h", i, st0, exp0); end
      checks++;
      if (st1 !== exp1) begin errors++; $display("FAIL reset_hold lsb cyc%0d: got %h expected %h", i, st1, exp1); end
    end
    reset = 1'b0; en = 1'b0; req = 8'h00;
    tick();
    checks++;
    if (st0 !== 13'h0) begin errors++; $display("FAIL reset_release msb: got %h expected %h", st0, 13'h0); end
    checks++;
    if (st1 !== 13'h0) begin errors++; $display("FAIL reset_release lsb: got %h expected %h", st1, 13'h0); end
  endtask

  task automatic test_drain;
    logic [12:0] e0 [4];
    logic [12:0] e1 [4];
    e0[0] = {1'b1, 3'd7, 8'hA4, 1'b0}; e1[0] = {1'b1, 3'd2, 8'hA4, 1'b0};
    e0[1] = {1'b1, 3'd5, 8'h24, 1'b0}; e1[1] = {1'b1, 3'd5, 8'hA0, 1'b0};
    e0[2] = {1'b1, 3'd2, 8'h04, 1'b0}; e1[2] = {1'b1, 3'd7, 8'h80, 1'b0};
    e0[3] = 13'h0;                     e1[3] = 13'h0;
    en = 1'b1; req = 8'b1010_0100; ready = 1'b1;
    tick();
    en = 1'b0; req = 8'h00;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (st0 !== e0[i]) begin errors++; $display("FAIL drain msb step%0d: got %h expected %h", i, st0, e0[i]); end
      checks++;
      if (st1 !== e1[i]) begin errors++; $display("FAIL drain lsb step%0d: got %h expected %h", i, st1, e1[i]); end
      tick();
    end
    ready = 1'b0;
  endtask

  task automatic test_backpressure;
    ready = 1'b0; en = 1'b1; req = 8'h10;
    tick();
    en = 1'b0; req = 8'h00;
    exp0 = {1'b1, 3'd4, 8'h10, 1'b0};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (st0 !== exp0) begin errors++; $display("FAIL bp_hold msb cyc%0d: got %h expected %h", i, st0, exp0); end
      tick();
    end
    en = 1'b1; req = 8'h40;
    tick();
    en = 1'b0; req = 8'h00;
    exp0 = {1'b1, 3'd6, 8'h50, 1'b0}; exp1 = {1'b1, 3'd4, 8'h50, 1'b0};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL bp_preempt msb: got %h expected %h", st0, exp0); end
    checks++;
    if (st1 !== exp1) begin errors++; $display("FAIL bp_preempt lsb: got %h expected %h", st1, exp1); end
    ready = 1'b1;
    tick();
    exp0 = {1'b1, 3'd4, 8'h10, 1'b0}; exp1 = {1'b1, 3'd6, 8'h40, 1'b0};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL bp_accept1 msb: got %h expected %h", st0, exp0); end
    checks++;
    if (st1 !== exp1) begin errors++; $display("FAIL bp_accept1 lsb: got %h expected %h", st1, exp1); end
    tick();
    checks++;
    if (st0 !== 13'h0) begin errors++; $display("FAIL bp_accept2 msb: got %h expected %h", st0, 13'h0); end
    checks++;
    if (st1 !== 13'h0) begin errors++; $display("FAIL bp_accept2 lsb: got %h expected %h", st1, 13'h0); end
    ready = 1'b0;
  endtask

  task automatic test_overflow;
    ready = 1'b0; en = 1'b1; req = 8'h10;
    tick();
    exp0 = {1'b1, 3'd4, 8'h10, 1'b0};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL ovf_setup msb: got %h expected %h", st0, exp0); end
    // Collide with the still-pending bit while the consumer stalls.
    tick();
    en = 1'b0; req = 8'h00;
    exp0 = {1'b1, 3'd4, 8'h10, 1'b1};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL ovf_pulse msb: got %h expected %h", st0, exp0); end
    checks++;
    if (st1 !== exp0) begin errors++; $display("FAIL ovf_pulse lsb: got %h expected %h", st1, exp0); end
    tick();
    exp0 = {1'b1, 3'd4, 8'h10, 1'b0};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL ovf_one_cycle msb: got %h expected %h", st0, exp0); end
    // Same collision but the bit is accepted in that cycle: set wins, no overflow.
    en = 1'b1; req = 8'h10; ready = 1'b1;
    tick();
    en = 1'b0; req = 8'h00; ready = 1'b0;
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL ovf_clr_set msb: got %h expected %h", st0, exp0); end
    checks++;
    if (st1 !== exp0) begin errors++; $display("FAIL ovf_clr_set lsb: got %h expected %h", st1, exp0); end
    tick();
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL ovf_clr_set_after msb: got %h expected %h", st0, exp0); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (st0 !== 13'h0) begin errors++; $display("FAIL ovf_drain msb: got %h expected %h", st0, 13'h0); end
  endtask

  task automatic test_enable;
    ready = 1'b0; en = 1'b1; req = 8'h01;
    tick();
    en = 1'b0; req = 8'hFF; ready = 1'b1;
    exp0 = {1'b1, 3'd0, 8'h01, 1'b0};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL en_setup msb: got %h expected %h", st0, exp0); end
    checks++;
    if (st1 !== exp0) begin errors++; $display("FAIL en_setup lsb: got %h expected %h", st1, exp0); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (st0 !== 13'h0) begin errors++; $display("FAIL en_gated msb cyc%0d: got %h expected %h", i, st0, 13'h0); end
      checks++;
      if (st1 !== 13'h0) begin errors++; $display("FAIL en_gated lsb cyc%0d: got %h expected %h", i, st1, 13'h0); end
    end
    req = 8'h00; ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    ready = 1'b0; en = 1'b1; req = 8'hF0;
    tick();
    en = 1'b0; req = 8'h00;
    exp0 = {1'b1, 3'd7, 8'hF0, 1'b0}; exp1 = {1'b1, 3'd4, 8'hF0, 1'b0};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL mid_setup msb: got %h expected %h", st0, exp0); end
    checks++;
    if (st1 !== exp1) begin errors++; $display("FAIL mid_setup lsb: got %h expected %h", st1, exp1); end
    ready = 1'b1;
    tick();
    exp0 = {1'b1, 3'd6, 8'h70, 1'b0}; exp1 = {1'b1, 3'd5, 8'hE0, 1'b0};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL mid_accept msb: got %h expected %h", st0, exp0); end
    checks++;
    if (st1 !== exp1) begin errors++; $display("FAIL mid_accept lsb: got %h expected %h", st1, exp1); end
    ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; ready = 1'b1;
    checks++;
    if (st0 !== 13'h0) begin errors++; $display("FAIL mid_reset msb: got %h expected %h", st0, 13'h0); end
    checks++;
    if (st1 !== 13'h0) begin errors++; $display("FAIL mid_reset lsb: got %h expected %h", st1, 13'h0); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (st0 !== 13'h0) begin errors++; $display("FAIL mid_no_stale msb cyc%0d: got %h expected %h", i, st0, 13'h0); end
    end
    ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    // Continuous ready with a fresh request arriving while draining.
    ready = 1'b1; en = 1'b1; req = 8'h81;
    tick();
    req = 8'h02;
    exp0 = {1'b1, 3'd7, 8'h81, 1'b0};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL b2b_0 msb: got %h expected %h", st0, exp0); end
    tick();
    en = 1'b0; req = 8'h00;
    exp0 = {1'b1, 3'd1, 8'h03, 1'b0}; exp1 = {1'b1, 3'd1, 8'h82, 1'b0};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL b2b_1 msb: got %h expected %h", st0, exp0); end
    checks++;
    if (st1 !== exp1) begin errors++; $display("FAIL b2b_1 lsb: got %h expected %h", st1, exp1); end
    tick();
    exp0 = {1'b1, 3'd0, 8'h01, 1'b0}; exp1 = {1'b1, 3'd7, 8'h80, 1'b0};
    checks++;
    if (st0 !== exp0) begin errors++; $display("FAIL b2b_2 msb: got %h expected %h", st0, exp0); end
    checks++;
    if (st1 !== exp1) begin errors++; $display("FAIL b2b_2 lsb: got %h expected %h", st1, exp1); end
    tick();
    checks++;
    if (st0 !== 13'h0) begin errors++; $display("FAIL b2b_3 msb: got %h expected %h", st0, 13'h0); end
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_drain();
    test_backpressure();
    test_overflow();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/priority_encoder_q.md
Name: priority_encoder_q

Overview:
- Sequential 8-to-3 priority encoder, the inverse of the team's 2-4/3-8 one-hot decoders.
- Captures multi-hot request bits into a pending register.
- Presents the index of the highest-priority pending bit on a valid/ready interface, and clears each bit as it is accepted.
- Used wherever one-hot event lines (buttons, decoder-selected strobes) must be serialized into binary codes for a downstream consumer.

Parameters:
- N, 8, request vector width (power of two, 2..32).
- LSB_FIRST, 0, priority direction: 0 = highest index wins, 1 = lowest index wins.
- W, $clog2(N), code width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  request capture enable; req is ignored when low.
- req  input  N  multi-hot request strobes, sampled on each rising edge while en=1.
- code  output  W  binary index of the selected pending bit; 0 when valid=0.
- valid  output  1  at least one bit pending (|pending).
- ready  input  1  consumer accepts code this cycle when valid=1.
- pending  output  N  current pending register, for debug and status.
- overflow  output  1  registered one-cycle pulse: a captured request hit an already-pending bit that was not cleared that cycle.

Behaviour:
- Single clock domain; clk and reset only. reset is synchronous and active-high.
- Reset values: pending=0, valid=0, code=0, overflow=0. reset has priority over all other inputs in the same cycle.
- State: pending_q[N-1:0] register and overflow_q register. No other state.
- Selection, combinational from pending_q:
  - sel = index of the highest set bit (LSB_FIRST=0) or lowest set bit (LSB_FIRST=1).
  - code = sel; valid = |pending_q; pending = pending_q.
  - Outputs depend only on registered state, never combinationally on req, en or ready.
- Accept: acc = valid & ready. clr_mask = acc ? (1<<sel) : 0.
- Capture: set_mask = en ? req : 0.
- Update per cycle: pending_q <= (pending_q & ~clr_mask) | set_mask.
- Latency:
  - A req bit captured at edge t appears in pending/valid after edge t.
  - The accepted bit is gone after the accept edge.
  - Next code is presented the following cycle. Throughput is one code per cycle under continuous ready.
- Backpressure: while valid=1 and ready=0, code and pending are held stable except for newly set bits. A newly set higher-priority bit preempts code on the next cycle; this is legal, and the consumer samples code only on accept.
- Simultaneous clear and set of the same bit: set wins. The bit stays pending and counts as a new event; no overflow.
- overflow_q <= |(set_mask & pending_q & ~clr_mask). Pulses for one cycle, the cycle after the colliding capture. The colliding request is merged, not queued twice.
- ready while valid=0: no effect. en=0: pending still drains normally.
- Reset mid-drain: all pending bits are discarded; valid=0 on the cycle after reset is sampled.
- No X-propagation: code is driven 0 when nothing is pending.

Test Plan:
- Reset: reset=1 for 2 cycles with en=1, req=8'hFF, ready=0 -> pending=0, valid=0, code=0, overflow=0 during reset and on the first cycle after release.
- Drain order: en=1, req=8'b1010_0100 for one cycle, ready=1 -> valid=1 for 3 cycles with code=7,5,2, then valid=0, pending=0. A LSB_FIRST=1 instance gives code=2,5,7.
- Backpressure and preemption: req=8'h10, ready=0 -> code=4 held for 10 cycles. Then req=8'h40 -> code=6 next cycle. ready=1 -> code 6 then 4 accepted.
- Overflow: pending=8'h10, ready=0, req=8'h10 -> overflow=1 for exactly one cycle, pending stays 8'h10. Repeat with ready=1 in the same cycle -> overflow=0, pending=8'h10, code=4 next cycle.
- Enable gating: en=0, req=8'hFF for 5 cycles with pending=8'h01, ready=1 -> code 0 accepted once, then valid=0, pending=0.
- Reset mid-operation: pending=8'hF0, 1 code accepted, then reset=1 for 1 cycle -> pending=0, valid=0 next cycle. No stale code appears afterwards.
